// File: rtl/responder_arbiter_pkg.sv
// Shared definitions for the quiz round controller: state encoding and 50 MHz defaults.
package responder_arbiter_pkg;

  localparam int unsigned STATE_W             = 3;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned BUZZ_CYCLES_DEF     = 25_000_000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_LOCKED  = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_FOUL    = 3'd4
  } state_e;

endpackage

// File: rtl/responder_arbiter_key_debounce.sv
// One active-low key: 2-FF synchroniser, stable-level debouncer and a press strobe
// on the accepted 1->0 transition.
module responder_arbiter_key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_ready;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_change;
  logic             w_pending;

  // r_ready stays low until a released level has been accepted, so a key held
  // through reset cannot produce a press until it is let go first.
  assign w_change  = r_sync1 != r_sync2;
  assign w_pending = (r_sync2 != r_level) || !r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_ready <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (w_change || !w_pending) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        if (r_sync2) begin
          r_ready <= 1'b1;
        end else if (r_ready && r_level) begin
          r_press <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/responder_arbiter.sv
// Quiz round controller: debounced keys drive a round FSM that arms the countdown,
// latches the first responder or false starter, and times the buzzer.
module responder_arbiter
  import responder_arbiter_pkg::*;
#(
  parameter int unsigned N_PLAYERS       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned BUZZ_CYCLES     = BUZZ_CYCLES_DEF
) (
  input  logic                 CLK,
  input  logic                 Rstn,
  input  logic                 Key_Host,
  input  logic [N_PLAYERS-1:0] Key_Player,
  input  logic                 Time_Up,
  output logic                 Timer_Start,
  output logic                 Round_Clear,
  output logic [N_PLAYERS-1:0] Winner,
  output logic [N_PLAYERS-1:0] Foul,
  output logic                 Buzzer,
  output logic [STATE_W-1:0]   State_Code
);

  localparam int unsigned BUZZ_W = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;

  logic                 w_host_press;
  logic [N_PLAYERS-1:0] w_player_press;
  logic [N_PLAYERS-1:0] w_first;
  logic                 w_any;

  state_e               r_state;
  state_e               w_next;
  logic                 w_win_load;
  logic                 w_foul_load;
  logic                 w_round_clear;
  logic                 w_buzz_start;

  logic                 r_timer_start;
  logic                 r_round_clear;
  logic [N_PLAYERS-1:0] r_winner;
  logic [N_PLAYERS-1:0] r_foul;
  logic                 r_buzzer;
  logic [BUZZ_W-1:0]    r_buzz_cnt;

  responder_arbiter_key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_host_db (
    .clk     (CLK),
    .rst_n   (Rstn),
    .i_key   (Key_Host),
    .o_press (w_host_press)
  );

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_player_db
    responder_arbiter_key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (CLK),
      .rst_n   (Rstn),
      .i_key   (Key_Player[g]),
      .o_press (w_player_press[g])
    );
  end

  // Isolate the lowest set bit so simultaneous presses resolve to the lowest index.
  assign w_first = w_player_press & (~w_player_press + N_PLAYERS'(1));
  assign w_any   = |w_player_press;

  always_comb begin
    w_next      = r_state;
    w_win_load  = 1'b0;
    w_foul_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_next      = ST_FOUL;
          w_foul_load = 1'b1;
        end else if (w_host_press) begin
          w_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_any) begin
          w_next     = ST_LOCKED;
          w_win_load = 1'b1;
        end else if (Time_Up) begin
          w_next = ST_TIMEOUT;
        end
      end
      ST_LOCKED, ST_TIMEOUT, ST_FOUL: begin
        if (w_host_press) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    w_round_clear = (r_state != ST_IDLE) && (w_next == ST_IDLE);
    w_buzz_start  = w_win_load || w_foul_load;
  end

  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      r_state       <= ST_IDLE;
      r_timer_start <= 1'b0;
      r_round_clear <= 1'b0;
      r_winner      <= '0;
      r_foul        <= '0;
    end else begin
      r_state       <= w_next;
      r_timer_start <= (w_next == ST_ARMED);
      r_round_clear <= w_round_clear;
      if (w_round_clear) begin
        r_winner <= '0;
        r_foul   <= '0;
      end else begin
        if (w_win_load)  r_winner <= w_first;
        if (w_foul_load) r_foul   <= w_first;
      end
    end
  end

  // Buzzer holds for BUZZ_CYCLES: the flag covers the cycle where the count sits at zero.
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      r_buzzer   <= 1'b0;
      r_buzz_cnt <= '0;
    end else if (w_round_clear) begin
      r_buzzer   <= 1'b0;
      r_buzz_cnt <= '0;
    end else if (w_buzz_start) begin
      r_buzzer   <= 1'b1;
      r_buzz_cnt <= BUZZ_W'(BUZZ_CYCLES - 1);
    end else if (r_buzzer) begin
      if (r_buzz_cnt == '0) begin
        r_buzzer <= 1'b0;
      end else begin
        r_buzz_cnt <= r_buzz_cnt - BUZZ_W'(1);
      end
    end
  end

  assign Timer_Start = r_timer_start;
  assign Round_Clear = r_round_clear;
  assign Winner      = r_winner;
  assign Foul        = r_foul;
  assign Buzzer      = r_buzzer;
  assign State_Code  = r_state;

endmodule

// File: tb/tb_responder_arbiter.sv
// Scoreboard bench for responder_arbiter: stimulus queues expected output snapshots
// with their cycle stamps; a negedge monitor pops one on every output change.
module tb_responder_arbiter;
  import responder_arbiter_pkg::*;

  localparam int unsigned NP = 4;

  logic          CLK = 1'b0;
  logic          Rstn;
  logic          Key_Host;
  logic [NP-1:0] Key_Player;
  logic          Time_Up;
  logic          Timer_Start;
  logic          Round_Clear;
  logic [NP-1:0] Winner;
  logic [NP-1:0] Foul;
  logic          Buzzer;
  logic [2:0]    State_Code;

  responder_arbiter #(
    .N_PLAYERS       (NP),
    .DEBOUNCE_CYCLES (4),
    .BUZZ_CYCLES     (8)
  ) dut (
    .CLK         (CLK),
    .Rstn        (Rstn),
    .Key_Host    (Key_Host),
    .Key_Player  (Key_Player),
    .Time_Up     (Time_Up),
    .Timer_Start (Timer_Start),
    .Round_Clear (Round_Clear),
    .Winner      (Winner),
    .Foul        (Foul),
    .Buzzer      (Buzzer),
    .State_Code  (State_Code)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [13:0] exp_snap[$];
  int          exp_cyc[$];
  wire  [13:0] w_snap = {State_Code, Timer_Start, Round_Clear, Winner, Foul, Buzzer};

  function automatic logic [13:0] mk(input logic [2:0] st, input logic ts, input logic rc,
                                     input logic [3:0] w, input logic [3:0] f, input logic bz);
    return {st, ts, rc, w, f, bz};
  endfunction

  task automatic expect_at(input logic [13:0] s, input int c);
    exp_snap.push_back(s);
    exp_cyc.push_back(c);
  endtask

  // Monitor: any change of the output tuple must match the next queued snapshot.
  bit          mon_en = 1'b0;
  logic [13:0] prev_snap;
  logic [13:0] m_snap;
  int          m_cyc;
  always @(negedge CLK) begin
    if (mon_en && (w_snap !== prev_snap)) begin
      checks++;
      if (exp_snap.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got %h at cycle %0d, required no change", w_snap, cyc);
      end else begin
        m_snap = exp_snap.pop_front();
        m_cyc  = exp_cyc.pop_front();
        if ((w_snap !== m_snap) || (m_cyc >= 0 && m_cyc != cyc)) begin
          errors++;
          $display("FAIL output_change: got %h at cycle %0d, required %h at cycle %0d",
                   w_snap, cyc, m_snap, m_cyc);
        end
      end
    end
    prev_snap = w_snap;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic key_down(input logic h, input logic [3:0] pm, output int t);
    Key_Host   = ~h;
    Key_Player = ~pm;
    t          = cyc;
  endtask

  task automatic release_settle();
    tick(10);
    Key_Host   = 1'b1;
    Key_Player = '1;
    tick(10);
  endtask

  task automatic direct_check(input string name, input logic [13:0] req);
    checks++;
    if (w_snap !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, w_snap, req);
    end
  endtask

  int t;

  initial begin
    Key_Host   = 1'b1;
    Key_Player = '1;
    Time_Up    = 1'b0;
    Rstn       = 1'b1;
    #1 Rstn    = 1'b0;
    tick(3);
    direct_check("reset_state", 14'h0);
    Rstn   = 1'b1;
    mon_en = 1'b1;
    tick(10);

    // Host press arms the round after 2 sync + 4 debounce + 1 register cycles.
    key_down(1'b1, 4'b0000, t);
    expect_at(mk(3'd1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0), t + 7);
    release_settle();
    // A 3-cycle glitch must not strobe a lock.
    Key_Player[1] = 1'b0;
    tick(3);
    Key_Player[1] = 1'b1;
    tick(10);

    // Player 2 locks, buzzer for 8 cycles; a later player 0 press is ignored.
    key_down(1'b0, 4'b0100, t);
    expect_at(mk(3'd2, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1), t + 7);
    expect_at(mk(3'd2, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0), t + 15);
    release_settle();
    key_down(1'b0, 4'b0001, t);
    release_settle();
    key_down(1'b1, 4'b0000, t);
    expect_at(mk(3'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0), t + 7);
    expect_at(14'h0, t + 8);
    release_settle();

    // Simultaneous players 3 and 1: lowest index wins.
    key_down(1'b1, 4'b0000, t);
    expect_at(mk(3'd1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0), t + 7);
    release_settle();
    key_down(1'b0, 4'b1010, t);
    expect_at(mk(3'd2, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1), t + 7);
    expect_at(mk(3'd2, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0), t + 15);
    release_settle();
    key_down(1'b1, 4'b0000, t);
    expect_at(mk(3'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0), t + 7);
    expect_at(14'h0, t + 8);
    release_settle();

    // False start from IDLE.
    key_down(1'b0, 4'b0001, t);
    expect_at(mk(3'd4, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b1), t + 7);
    expect_at(mk(3'd4, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0), t + 15);
    release_settle();
    key_down(1'b1, 4'b0000, t);
    expect_at(mk(3'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0), t + 7);
    expect_at(14'h0, t + 8);
    release_settle();

    // Timeout: no buzzer from this block.
    key_down(1'b1, 4'b0000, t);
    expect_at(mk(3'd1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0), t + 7);
    release_settle();
    Time_Up = 1'b1;
    expect_at(mk(3'd3, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0), cyc + 1);
    tick(1);
    Time_Up = 1'b0;
    tick(3);
    key_down(1'b1, 4'b0000, t);
    expect_at(mk(3'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0), t + 7);
    expect_at(14'h0, t + 8);
    release_settle();

    // Player strobe coincident with Time_Up locks; then async reset mid-buzz.
    key_down(1'b1, 4'b0000, t);
    expect_at(mk(3'd1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0), t + 7);
    release_settle();
    key_down(1'b0, 4'b1000, t);
    expect_at(mk(3'd2, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b1), t + 7);
    tick(6);
    Time_Up = 1'b1;
    tick(1);
    Time_Up = 1'b0;
    tick(2);
    expect_at(14'h0, -1);
    #2 Rstn = 1'b0;
    #1 direct_check("async_reset", 14'h0);
    tick(2);
    Rstn = 1'b1;
    tick(12);
    Key_Player = '1;
    tick(12);

    // Recovery: a fresh host press arms normally.
    key_down(1'b1, 4'b0000, t);
    expect_at(mk(3'd1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0), t + 7);
    release_settle();

    checks++;
    if (exp_snap.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: got %0d outstanding, required 0", exp_snap.size());
    end
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
